alu_ctrl_sequencer: RTL

- Parametrised, registered successor to the combinational ALU control decoder in the EX stage.
- Accepts one opcode per handshake and emits the ALU control word plus the mem-stage mux-source bit.
- Holds the control word for the full latency of multi-cycle ops (mul, div, swap) and back-pressures ID/EX with a stall until the op completes.
- Flags illegal opcodes and supports a pipeline flush.

---
 rtl/alu_ctrl_sequencer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/alu_ctrl_sequencer.sv
// ----------------------------------------------------------------------------
// alu_ctrl_sequencer
//
// Registered ALU control sequencer for the EX stage. It takes one opcode per
// valid/ready handshake and decodes it into the ALU control word and the
// mem-stage mux-source bit. Multi-cycle ops (mul, div, swap) hold the control
// word for their full latency, and the block back-pressures ID/EX with a stall
// until the op completes. Illegal opcodes are flagged, and a pipeline flush
// kills the op that is in flight.
//
// Optional feature: define ALU_CTRL_PERF_EN to add a saturating 16-bit counter
// of producer stall cycles (perf_stall_cnt).
//
// Parameters:
//   OP_W     : opcode width (>= 4)
//   CTRL_W   : control word width (>= 5); bit CTRL_W-1 is the mem-stage mux source
//   MUL_LAT  : cycles ctrl is held for multiply (1..15)
//   DIV_LAT  : cycles ctrl is held for divide   (1..15)
//   SWAP_LAT : cycles ctrl is held for swap     (1..15)
//
// Ports:
//   clk            : clock, rising edge
//   rst_n          : asynchronous active-low reset
//   in_valid       : opcode is valid
//   in_ready       : sequencer can accept an opcode this cycle
//   opcode         : instruction ALU-op field
//   flush          : synchronous kill of the in-flight op
//   out_valid      : ctrl is valid this cycle
//   ctrl           : ALU control word (registered)
//   mem_src        : copy of ctrl[CTRL_W-1]
//   last           : final cycle of the current op
//   stall          : inverse of in_ready; drives the ID/EX hold
//   op_illegal     : current op was illegal (only meaningful with out_valid)
//   perf_stall_cnt : cycles with in_valid && !in_ready (ALU_CTRL_PERF_EN only)
// ----------------------------------------------------------------------------
module alu_ctrl_sequencer #(
    parameter int OP_W     = 4,
    parameter int CTRL_W   = 5,
    parameter int MUL_LAT  = 3,
    parameter int DIV_LAT  = 8,
    parameter int SWAP_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   opcode,
    input  logic              flush,
    output logic              out_valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic              mem_src,
    output logic              last,
    output logic              stall,
    output logic              op_illegal
`ifdef ALU_CTRL_PERF_EN
    ,
    output logic [15:0]       perf_stall_cnt
`endif
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic              illegal;
        logic [3:0]        lat;
    } dec_t;

    // Decode one opcode into control word, illegal flag and hold latency.
    // For the legal range 0..9 the low control bits are simply the opcode.
    function automatic dec_t decode_op(input logic [OP_W-1:0] op);
        dec_t d;
        d.ctrl    = '0;
        d.illegal = 1'b0;
        d.lat     = 4'd1;
        if (op > OP_W'(4'd9)) begin
            d.illegal = 1'b1;
        end else begin
            d.ctrl[3:0] = op[3:0];
            case (op[3:0])
                4'd2: d.lat = 4'(MUL_LAT);
                4'd3: d.lat = 4'(DIV_LAT);
                4'd5: begin
                    d.lat              = 4'(SWAP_LAT);
                    d.ctrl[CTRL_W-1]   = 1'b1;
                end
                default: d.lat = 4'd1;
            endcase
        end
        return d;
    endfunction

    state_t            state_r;
    logic [3:0]        cnt_r;
    logic              out_valid_r;
    logic [CTRL_W-1:0] ctrl_r;
    logic              mem_src_r;
    logic              last_r;
    logic              op_illegal_r;

    logic              in_ready_s;
    logic              accept_s;
    dec_t              dec_s;

    // Ready whenever idle or on the final cycle of the current op, so
    // single-cycle ops stream back to back without a bubble.
    always_comb begin
        in_ready_s = 1'b0;
        accept_s   = 1'b0;
        dec_s      = decode_op(opcode);
        if (state_r == IDLE) begin
            in_ready_s = 1'b1;
        end else if (cnt_r == 4'd1) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
        accept_s = in_valid && in_ready_s;
    end

    // Sequencer FSM: load on accept, count down the hold, return to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= 4'd0;
            out_valid_r  <= 1'b0;
            ctrl_r       <= '0;
            mem_src_r    <= 1'b0;
            last_r       <= 1'b0;
            op_illegal_r <= 1'b0;
        end else if (flush) begin
            // Flush wins over a same-cycle accept; the new opcode is dropped.
            state_r      <= IDLE;
            cnt_r        <= 4'd0;
            out_valid_r  <= 1'b0;
            ctrl_r       <= '0;
            mem_src_r    <= 1'b0;
            last_r       <= 1'b0;
            op_illegal_r <= 1'b0;
        end else if (accept_s) begin
            state_r      <= EXEC;
            cnt_r        <= dec_s.lat;
            out_valid_r  <= 1'b1;
            ctrl_r       <= dec_s.ctrl;
            mem_src_r    <= dec_s.ctrl[CTRL_W-1];
            last_r       <= (dec_s.lat == 4'd1);
            op_illegal_r <= dec_s.illegal;
        end else if ((state_r == EXEC) && (cnt_r > 4'd1)) begin
            // Hold the control word; last is registered one cycle ahead.
            cnt_r  <= cnt_r - 4'd1;
            last_r <= (cnt_r == 4'd2);
        end else if (state_r == EXEC) begin
            // Op completed with no follow-on accept.
            state_r      <= IDLE;
            cnt_r        <= 4'd0;
            out_valid_r  <= 1'b0;
            ctrl_r       <= '0;
            mem_src_r    <= 1'b0;
            last_r       <= 1'b0;
            op_illegal_r <= 1'b0;
        end else begin
            state_r <= state_r;
        end
    end

`ifdef ALU_CTRL_PERF_EN
    logic [15:0] perf_stall_cnt_r;

    // Saturating count of cycles where the producer is held off; flush does not clear it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt_r <= 16'h0000;
        end else if (in_valid && !in_ready_s && (perf_stall_cnt_r != 16'hFFFF)) begin
            perf_stall_cnt_r <= perf_stall_cnt_r + 16'h0001;
        end else begin
            perf_stall_cnt_r <= perf_stall_cnt_r;
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_r;
`endif

    assign in_ready   = in_ready_s;
    assign stall      = !in_ready_s;
    assign out_valid  = out_valid_r;
    assign ctrl       = ctrl_r;
    assign mem_src    = mem_src_r;
    assign last       = last_r;
    assign op_illegal = op_illegal_r;

endmodule
